// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the fetch/data memory port arbiter.
// Optional build macro: ARB_ROUND_ROBIN_EN (alternate grants on a tie).
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between fetch and memory-stage requests.
// ARB_ROUND_ROBIN_EN: a tie goes to the side not served last; otherwise data always wins.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   inst_req,
    input  logic   data_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  owner_e last_owner,
`endif
    output logic   grant,
    output owner_e owner
);

    always_comb begin
        grant = inst_req | data_req;
        owner = OWN_DATA;
        if (!data_req) begin
            owner = OWN_INST;
        end
`ifdef ARB_ROUND_ROBIN_EN
        else if (inst_req && (last_owner == OWN_DATA)) begin
            owner = OWN_INST;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between fetch and memory stage, one transaction in flight.
// ARB_ROUND_ROBIN_EN: keeps a last-owner flag so fetch is not starved on ties.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  inst_req,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic [DATA_W-1:0]     inst_rdata,
    output logic                  inst_done,

    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    input  logic [DATA_W/8-1:0]   data_wstrb,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  data_done,

    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic                  busy
);

    state_e                state_q, state_d;
    owner_e                owner_q;
    logic                  pick_grant;
    owner_e                pick_owner;
    logic                  accept;
    logic                  capture;

    logic                  mem_wr_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [DATA_W-1:0]     mem_wdata_q;
    logic [DATA_W/8-1:0]   mem_wstrb_q;
    logic [DATA_W-1:0]     hold_q;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e                last_q;
`endif

    arb_pick u_pick (
        .inst_req   (inst_req),
        .data_req   (data_req),
`ifdef ARB_ROUND_ROBIN_EN
        .last_owner (last_q),
`endif
        .grant      (pick_grant),
        .owner      (pick_owner)
    );

    assign accept = (state_q == IDLE) && pick_grant;

    // A data_ok is only meaningful once the address has been (or is being) accepted.
    assign capture = ((state_q == ADDR) && mem_addr_ok && mem_data_ok) ||
                     ((state_q == WAIT) && mem_data_ok);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_grant) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (mem_addr_ok) begin
                    state_d = mem_data_ok ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (mem_data_ok) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q     <= OWN_INST;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else if (accept) begin
            owner_q <= pick_owner;
            if (pick_owner == OWN_DATA) begin
                mem_wr_q    <= data_wr;
                mem_addr_q  <= data_addr;
                mem_wdata_q <= data_wdata;
                mem_wstrb_q <= data_wr ? data_wstrb : '0;
            end else begin
                mem_wr_q    <= 1'b0;
                mem_addr_q  <= inst_addr;
                mem_wdata_q <= '0;
                mem_wstrb_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
        end else if (capture) begin
            hold_q <= mem_rdata;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Resets to "inst served last" so the first tie goes to data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= OWN_INST;
        end else if (accept) begin
            last_q <= pick_owner;
        end
    end
`endif

    // All control outputs decode the state directly so reset clears them at once.
    assign mem_req    = (state_q == ADDR);
    assign busy       = (state_q != IDLE);
    assign inst_done  = (state_q == RESP) && (owner_q == OWN_INST);
    assign data_done  = (state_q == RESP) && (owner_q == OWN_DATA);

    assign mem_wr     = mem_wr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign inst_rdata = hold_q;
    assign data_rdata = hold_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus randomized transactions
// against a transaction-level model (grant choice, latched fields, done timing).
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_done;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic [31:0] data_rdata;
    logic        data_done;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: 1 when the data side received the most recent grant.
    bit last_data = 1'b0;

    mem_port_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_rdata  (inst_rdata),
        .inst_done   (inst_done),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_wstrb  (data_wstrb),
        .data_rdata  (data_rdata),
        .data_done   (data_done),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit pick_data(input bit ireq, input bit dreq);
`ifdef ARB_ROUND_ROBIN_EN
        if (ireq && dreq) return !last_data;
`endif
        return dreq;
    endfunction

    // Starts in an IDLE cycle, runs one full transaction, ends in the following IDLE cycle.
    // aw: cycles mem_addr_ok is withheld; dw: cycles from address accept to data_ok (0 = same).
    task automatic run_txn(input bit ireq, input bit dreq, input bit dwr,
                           input logic [31:0] iaddr, input logic [31:0] daddr,
                           input logic [31:0] wd, input logic [3:0] ws,
                           input int aw, input int dw, input logic [31:0] rd);
        bit          win_d;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_ws;

        chk("idle_busy", busy, 0);
        chk("idle_mem_req", mem_req, 0);
        inst_req   = ireq;
        data_req   = dreq;
        data_wr    = dwr;
        inst_addr  = iaddr;
        data_addr  = daddr;
        data_wdata = wd;
        data_wstrb = ws;
        mem_data_ok = 1'($urandom_range(0, 1));
        mem_rdata   = $urandom;

        win_d     = pick_data(ireq, dreq);
        last_data = win_d;
        e_wr      = win_d ? dwr : 1'b0;
        e_addr    = win_d ? daddr : iaddr;
        e_wdata   = wd;
        e_ws      = (win_d && dwr) ? ws : 4'h0;

        step();
        mem_data_ok = 1'b0;
        for (int k = 0; k <= aw; k++) begin
            chk("addr_mem_req", mem_req, 1);
            chk("addr_busy", busy, 1);
            chk("addr_mem_wr", mem_wr, e_wr);
            chk("addr_mem_addr", mem_addr, e_addr);
            chk("addr_mem_wstrb", mem_wstrb, e_ws);
            if (win_d) chk("addr_mem_wdata", mem_wdata, e_wdata);
            chk("addr_no_done", {inst_done, data_done}, 0);
            if (k < aw) begin
                data_addr   = $urandom;
                data_wdata  = $urandom;
                data_wstrb  = 4'($urandom);
                data_wr     = 1'($urandom);
                inst_addr   = $urandom;
                mem_data_ok = 1'($urandom_range(0, 1));
                mem_rdata   = $urandom;
                step();
                mem_data_ok = 1'b0;
            end
        end
        mem_addr_ok = 1'b1;
        if (dw == 0) begin
            mem_data_ok = 1'b1;
            mem_rdata   = rd;
        end
        step();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = $urandom;
        if (dw > 0) begin
            for (int k = 1; k < dw; k++) begin
                chk("wait_mem_req", mem_req, 0);
                chk("wait_busy", busy, 1);
                chk("wait_no_done", {inst_done, data_done}, 0);
                step();
            end
            chk("wait_mem_req", mem_req, 0);
            mem_data_ok = 1'b1;
            mem_rdata   = rd;
            step();
            mem_data_ok = 1'b0;
            mem_rdata   = $urandom;
        end
        chk("resp_inst_done", inst_done, !win_d);
        chk("resp_data_done", data_done, win_d);
        chk("resp_inst_rdata", inst_rdata, rd);
        chk("resp_data_rdata", data_rdata, rd);
        chk("resp_mem_req", mem_req, 0);
        if (win_d) data_req = 1'b0;
        else       inst_req = 1'b0;
        step();
        chk("post_no_done", {inst_done, data_done}, 0);
    endtask

    initial begin
        bit          ri, rdq;
        logic [31:0] ia;
        rst = 1'b0;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_addr = '0; data_wdata = '0; data_wstrb = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_done", {inst_done, data_done}, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wstrb", mem_wstrb, 0);
        chk("rst_hold", data_rdata, 0);
        step();
        rst = 1'b1;

        run_txn(0, 1, 0, 32'h0, 32'h1000, 32'h0, 4'h0, 0, 1, 32'hDEADBEEF);
        run_txn(0, 1, 1, 32'h0, 32'h2000, 32'h0000ABCD, 4'h3, 1, 2, 32'h0BAD0BAD);
        run_txn(1, 0, 0, 32'h400, 32'h3000, 32'h55, 4'hF, 0, 1, 32'h24020001);
        run_txn(0, 1, 1, 32'h0, 32'h4000, 32'h12345678, 4'hC, 4, 1, 32'h11112222);
        run_txn(0, 1, 0, 32'h0, 32'h5000, 32'h0, 4'h0, 0, 0, 32'hCAFEF00D);
        run_txn(1, 0, 0, 32'h404, 32'h0, 32'h0, 4'h0, 2, 0, 32'h8C430004);

        // Asynchronous reset while the address phase is active.
        data_req = 1'b1; data_addr = 32'h6000;
        step();
        chk("pre_rst_addr_req", mem_req, 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_addr_mem_req", mem_req, 0);
        chk("rst_addr_busy", busy, 0);
        chk("rst_addr_mem_addr", mem_addr, 0);
        data_req = 1'b0;
        step();
        rst = 1'b1;
        last_data = 1'b0;

        // Asynchronous reset while waiting for data.
        data_req = 1'b1; data_addr = 32'h7000;
        step();
        mem_addr_ok = 1'b1;
        step();
        mem_addr_ok = 1'b0;
        chk("pre_rst_wait_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_wait_busy", busy, 0);
        chk("rst_wait_mem_req", mem_req, 0);
        chk("rst_wait_done", {inst_done, data_done}, 0);
        chk("rst_wait_hold", data_rdata, 0);
        data_req = 1'b0;
        step();
        rst = 1'b1;
        last_data = 1'b0;

        // Ties with both sides held; the model decides who wins each round.
        run_txn(1, 1, 0, 32'h800, 32'h9000, 32'h0, 4'h0, 0, 1, 32'hA0A0A0A0);
        run_txn(1, 1, 0, 32'h800, 32'h9004, 32'h0, 4'h0, 0, 1, 32'hB1B1B1B1);
        run_txn(1, 1, 1, 32'h800, 32'h9008, 32'h77, 4'h1, 0, 0, 32'hC2C2C2C2);
        if (inst_req) run_txn(1, 0, 0, 32'h800, 32'h0, 32'h0, 4'h0, 0, 1, 32'hD3D3D3D3);

        for (int n = 0; n < 40; n++) begin
            ri  = inst_req | 1'($urandom);
            rdq = data_req | 1'($urandom);
            if (!ri && !rdq) rdq = 1'b1;
            ia = inst_req ? inst_addr : $urandom;
            run_txn(ri, rdq, 1'($urandom), ia, $urandom, $urandom, 4'($urandom),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
